mac_vector_ctrl: RTL
====================

// Module: mac_vector_ctrl
// PURPOSE
// - Initiator for a load_accum-style MAC (P <= P +/- A*B when load=1; P holds when load=0).
// - Accepts a stream of signed operand pairs over valid/ready and drives the MAC operand and control pins.
// - Clears the accumulator before each vector, waits out MAC latency after the last beat, then returns P over valid/ready.
// PARAMETERS
// A_W      20  operand A width (signed)
// B_W      18  operand B width (signed)
// P_W      38  accumulator width; P_W >= A_W+B_W
// MAC_LAT  1   clocks from MAC input sample to P update (>=1)
// MAX_LEN  16  max beats per vector; CW = $clog2(MAX_LEN+1)
// PORTS
// clk       in   1     clock, rising edge
// reset     in   1     asynchronous, active-high
// s_valid   in   1     operand beat valid
// s_ready   out  1     beat accepted when s_valid & s_ready
// s_a       in   A_W   operand A
// s_b       in   B_W   operand B
// s_sub     in   1     beat is subtracted (P - A*B) when 1, else added
// s_last    in   1     final beat of vector
// mac_a     out  A_W   to MAC A
// mac_b     out  B_W   to MAC B
// mac_sub   out  1     to MAC subtract_i
// mac_load  out  1     to MAC load_acc_i
// mac_clr   out  1     to MAC reset (synchronous to clk)
// mac_p     in   P_W   from MAC P
// m_valid   out  1     result valid
// m_ready   in   1     result consumed when m_valid & m_ready
// m_result  out  P_W   accumulated value
// m_count   out  CW    beats in vector
// m_err     out  1     vector truncated at MAX_LEN
// BEHAVIOUR
// - All outputs registered. Reset: state=CLEAR, mac_clr=1, all other outputs 0.
// - FSM CLEAR: mac_clr=1, s_ready=0, beat counter=0; -> ACCUM next clock.
// - ACCUM: s_ready=1. Accepted beat: mac_a/mac_b/mac_sub <= s_a/s_b/s_sub, mac_load<=1 for one clock, count++.
//   No beat: mac_load<=0, mac_a/mac_b/mac_sub hold.
// - End of vector: accepted beat with s_last=1, or accepted beat when count==MAX_LEN-1 (sets err if s_last=0) -> DRAIN.
// - DRAIN: s_ready=0, mac_load=0 after the final beat's load cycle. Lasts MAC_LAT+1 clocks after the accepting edge.
//   On the last DRAIN edge: m_result<=mac_p, m_count<=count, m_err<=err, m_valid<=1; -> RESULT.
// - RESULT: outputs held stable while m_valid=1 & m_ready=0.
//   On handshake, m_valid<=0 the same edge; -> CLEAR. m_result/m_count/m_err hold until the next capture.
// - Arithmetic is performed by the MAC; P_W is sized so one full-scale product never overflows.
//   Overflow of the running sum over MAX_LEN beats wraps mod 2^P_W (not detected).
// - Beat on the same edge as s_last and count==MAX_LEN-1: normal end, err=0.
// - Reset mid-vector: immediate return to reset values; partial sum discarded via mac_clr.
// - m_ready while m_valid=0: ignored. s_valid outside ACCUM: not accepted (s_ready=0).
// TESTING
// 1 reset pulse -> mac_clr=1, m_valid=0, s_ready=0; s_ready=1 two clocks after release.
// 2 beats (5,2,+),(3,4,+),(7,6,-),last -> m_result=-20, m_count=3, m_err=0.
// 3 single beat A=-524288,B=-131072,+,last -> m_result=68719476736 (no overflow).
// 4 hold m_ready=0 for 5 clocks after m_valid -> m_valid, m_result stable, s_ready=0; then one handshake -> CLEAR.
// 5 s_valid gaps of 3 idle clocks between beats of test 2 -> mac_load=0 in gaps, m_result=-20.
// 6 MAX_LEN=4, 4 beats (1,1,+) no last -> m_result=4, m_count=4, m_err=1; reset after 2 beats of a new vector -> next vector (2,3,+),last gives 6.

Source files
------------

// File: rtl/mac_vector_ctrl.sv
// rtl/mac_vector_ctrl.sv - operand-stream initiator for a load/accumulate MAC
//
// Accepts signed (A, B, sub) beats over s_valid/s_ready and forwards each one
// to the MAC with a single-cycle mac_load. The MAC is cleared before every
// vector. After the final beat the controller waits out the MAC latency and
// then presents P over m_valid/m_ready.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready       operand beat handshake
//   s_a, s_b, s_sub       operands and add/subtract select
//   s_last                final beat of the vector
//   mac_a, mac_b, mac_sub MAC operand and subtract pins
//   mac_load, mac_clr     MAC accumulate enable and synchronous clear
//   mac_p                 MAC accumulator value
//   m_valid/m_ready       result handshake
//   m_result, m_count     accumulated value and number of beats
//   m_err                 vector was cut off at MAX_LEN without s_last
module mac_vector_ctrl #(
  parameter int A_W     = 20,
  parameter int B_W     = 18,
  parameter int P_W     = 38,
  parameter int MAC_LAT = 1,
  parameter int MAX_LEN = 16,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [A_W-1:0] s_a,
  input  logic [B_W-1:0] s_b,
  input  logic           s_sub,
  input  logic           s_last,
  output logic [A_W-1:0] mac_a,
  output logic [B_W-1:0] mac_b,
  output logic           mac_sub,
  output logic           mac_load,
  output logic           mac_clr,
  input  logic [P_W-1:0] mac_p,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [P_W-1:0] m_result,
  output logic [CW-1:0]  m_count,
  output logic           m_err
);

  localparam int DW = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           s_ready_q, s_ready_d;
  logic [A_W-1:0] mac_a_q, mac_a_d;
  logic [B_W-1:0] mac_b_q, mac_b_d;
  logic           mac_sub_q, mac_sub_d;
  logic           mac_load_q, mac_load_d;
  logic           mac_clr_q, mac_clr_d;
  logic           m_valid_q, m_valid_d;
  logic [P_W-1:0] m_result_q, m_result_d;
  logic [CW-1:0]  m_count_q, m_count_d;
  logic           m_err_q, m_err_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;
  logic [DW-1:0]  drain_q, drain_d;

  // s_ready is only ever high in ACCUM, so it doubles as the state qualifier.
  logic accept;
  assign accept = s_valid & s_ready_q;

  always_comb begin
    state_d    = state_q;
    s_ready_d  = 1'b0;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_sub_d  = mac_sub_q;
    mac_load_d = 1'b0;
    mac_clr_d  = 1'b0;
    m_valid_d  = m_valid_q;
    m_result_d = m_result_q;
    m_count_d  = m_count_q;
    m_err_d    = m_err_q;
    count_d    = count_q;
    err_d      = err_q;
    drain_d    = drain_q;

    case (state_q)
      CLEAR: begin
        // mac_clr was raised on entry; the MAC clears on this edge.
        count_d = '0;
        err_d   = 1'b0;
        state_d = ACCUM;
      end
      ACCUM: begin
        s_ready_d = 1'b1;
        if (accept) begin
          mac_a_d    = s_a;
          mac_b_d    = s_b;
          mac_sub_d  = s_sub;
          mac_load_d = 1'b1;
          count_d    = count_q + CW'(1);
          if (s_last || (count_q == CW'(MAX_LEN - 1))) begin
            err_d     = ~s_last;
            s_ready_d = 1'b0;
            drain_d   = '0;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        // One edge for the MAC to sample the final beat, MAC_LAT more for P.
        if (drain_q == DW'(MAC_LAT)) begin
          m_result_d = mac_p;
          m_count_d  = count_q;
          m_err_d    = err_q;
          m_valid_d  = 1'b1;
          state_d    = RESULT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      RESULT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          mac_clr_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      default: begin
        mac_clr_d = 1'b1;
        state_d   = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      s_ready_q  <= 1'b0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_sub_q  <= 1'b0;
      mac_load_q <= 1'b0;
      mac_clr_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      m_count_q  <= '0;
      m_err_q    <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_sub_q  <= mac_sub_d;
      mac_load_q <= mac_load_d;
      mac_clr_q  <= mac_clr_d;
      m_valid_q  <= m_valid_d;
      m_result_q <= m_result_d;
      m_count_q  <= m_count_d;
      m_err_q    <= m_err_d;
      count_q    <= count_d;
      err_q      <= err_d;
      drain_q    <= drain_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_sub  = mac_sub_q;
  assign mac_load = mac_load_q;
  assign mac_clr  = mac_clr_q;
  assign m_valid  = m_valid_q;
  assign m_result = m_result_q;
  assign m_count  = m_count_q;
  assign m_err    = m_err_q;

endmodule
